// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin host/DPU arbiter with lock for one single-port SRAM
// Defining SRAM_ARB_STATS_EN adds saturating per-requester grant counters.
module sram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
`ifdef SRAM_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sram_csb_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  h_gnt_cnt,
  output logic [CNT_W-1:0]  d_gnt_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_CAP = 2'd1, RD_OUT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_H = 2'd1, OWN_D = 2'd2} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              last_d_q, last_d_d;   // previous grant went to the DPU
  logic              rd_d_q, rd_d_d;       // read in flight belongs to the DPU
  logic [DATA_W-1:0] h_rdata_q, h_rdata_d, d_rdata_q, d_rdata_d;
  logic              h_elig, d_elig, pick_d, grant, win_we, win_lock;

  always_comb begin
    h_elig = 1'b0;
    d_elig = 1'b0;
    // The SRAM output register is busy during RD_CAP, so nobody is granted there.
    if (rst_n && state_q != RD_CAP) begin
      h_elig = h_req && (owner_q != OWN_D);
      d_elig = d_req && (owner_q != OWN_H);
    end
    pick_d   = d_elig && (!h_elig || !last_d_q);
    grant    = h_elig || d_elig;
    h_gnt    = h_elig && !pick_d;
    d_gnt    = pick_d;
    win_we   = pick_d ? d_we : h_we;
    win_lock = pick_d ? d_lock : h_lock;

    sram_csb_n = 1'b1;
    sram_we_n  = 1'b1;
    sram_addr  = '0;
    sram_din   = '0;
    if (grant) begin
      sram_csb_n = 1'b0;
      sram_we_n  = !win_we;
      sram_addr  = pick_d ? d_addr : h_addr;
      sram_din   = pick_d ? d_wdata : h_wdata;
    end

    h_rvalid = (state_q == RD_OUT) && !rd_d_q;
    d_rvalid = (state_q == RD_OUT) && rd_d_q;
  end

  always_comb begin
    state_d   = IDLE;
    owner_d   = owner_q;
    last_d_d  = last_d_q;
    rd_d_d    = rd_d_q;
    h_rdata_d = h_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == RD_CAP) begin
      state_d = RD_OUT;
      if (rd_d_q) d_rdata_d = sram_dout;
      else        h_rdata_d = sram_dout;
    end else if (grant && !win_we) begin
      state_d = RD_CAP;
      rd_d_d  = pick_d;
    end
    if ((owner_q == OWN_H && !h_lock) || (owner_q == OWN_D && !d_lock)) owner_d = OWN_NONE;
    if (grant) begin
      last_d_d = pick_d;
      if (win_lock) owner_d = pick_d ? OWN_D : OWN_H;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      last_d_q  <= 1'b1;
      rd_d_q    <= 1'b0;
      h_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_d_q  <= last_d_d;
      rd_d_q    <= rd_d_d;
      h_rdata_q <= h_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign h_rdata = h_rdata_q;
  assign d_rdata = d_rdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, d_cnt_q, d_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    d_cnt_d = d_cnt_q;
    if (h_gnt && h_cnt_q != '1) h_cnt_d = h_cnt_q + 1'b1;
    if (d_gnt && d_cnt_q != '1) d_cnt_d = d_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  assign h_gnt_cnt = h_cnt_q;
  assign d_gnt_cnt = d_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed and randomized checks of sram_port_arbiter against a bench model
module tb_sram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h_req, h_we, h_lock, d_req, d_we, d_lock;
  logic [AW-1:0] h_addr, d_addr, sram_addr;
  logic [DW-1:0] h_wdata, d_wdata, sram_din, sram_dout, h_rdata, d_rdata;
  logic          h_gnt, h_rvalid, d_gnt, d_rvalid, sram_csb_n, sram_we_n;
`ifdef SRAM_ARB_STATS_EN
  logic [1:0]    h_gnt_cnt, d_gnt_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [32];
  logic          mem_init = 1'b0;

  typedef struct {int port; logic [DW-1:0] data; int due;} rd_t;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)
`ifdef SRAM_ARB_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_csb_n(sram_csb_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef SRAM_ARB_STATS_EN
    , .h_gnt_cnt(h_gnt_cnt), .d_gnt_cnt(d_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      sram_dout <= '0;
      mem_init  <= 1'b1;
    end else if (!sram_csb_n) begin
      if (!sram_we_n) mem[sram_addr] <= sram_din;
      else            sram_dout <= mem[sram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    tick();
    h_req = 1; d_req = 1; rst_n = 0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, h_rvalid, d_rvalid} !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_rvalid: got %b expected 0000", {h_gnt, d_gnt, h_rvalid, d_rvalid}); end
    n_checks++; if ({sram_csb_n, sram_we_n} !== 2'b11) begin n_fail++; $display("FAIL reset_strobes: got %b expected 11", {sram_csb_n, sram_we_n}); end
    n_checks++; if ({sram_addr, sram_din} !== '0) begin n_fail++; $display("FAIL reset_addr_din: got %h/%h expected 0/0", sram_addr, sram_din); end
    n_checks++; if ({h_rdata, d_rdata} !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", h_rdata, d_rdata); end
    tick();
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    h_req = 1; h_we = 1; h_addr = 5'd3; h_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", h_gnt); end
    n_checks++; if ({sram_csb_n, sram_we_n, sram_addr, sram_din} !== {1'b0, 1'b0, 5'd3, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_bus: got %b %b %h %h expected 0 0 03 deadbeef", sram_csb_n, sram_we_n, sram_addr, sram_din); end
    tick(); h_we = 0;
    @(negedge clk);
    n_checks++; if ({h_gnt, sram_csb_n, sram_we_n, sram_addr} !== {1'b1, 1'b0, 1'b1, 5'd3}) begin n_fail++; $display("FAIL rd_gnt_bus: got %b %b %b %h expected 1 0 1 03", h_gnt, sram_csb_n, sram_we_n, sram_addr); end
    tick(); h_req = 0;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, h_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rd_cap_idle: got %b expected 000", {h_gnt, d_gnt, h_rvalid}); end
    tick();
    @(negedge clk);
    n_checks++; if ({h_rvalid, h_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_data: got %b %h expected 1 deadbeef", h_rvalid, h_rdata); end
    tick();
    @(negedge clk);
    n_checks++; if (h_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got %b expected 0", h_rvalid); end
    tick();
  endtask

  task automatic test_round_robin();
    int hn, dn;
    hn = 0; dn = 0;
    apply_reset();
    h_req = 1; d_req = 1; h_we = 1; d_we = 1;
    for (int i = 0; i < 8; i++) begin
      h_addr = 5'(8 + i); d_addr = 5'(8 + i);
      h_wdata = 32'h1000_0000 + 32'(i); d_wdata = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      n_checks++; if ({h_gnt, d_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_cycle%0d: got h/d %b expected %b", i, {h_gnt, d_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      if (h_gnt) hn++;
      if (d_gnt) dn++;
      tick();
      if (hn == 4) h_req = 0;
      if (dn == 4) d_req = 0;
    end
    h_req = 0; d_req = 0;
  endtask

  task automatic test_lock();
    d_req = 1; d_we = 0; d_addr = 5'd7; d_lock = 1;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_rd_gnt: got %b expected 01", {h_gnt, d_gnt}); end
    tick();
    d_we = 1; d_wdata = 32'h7777_0007;
    h_req = 1; h_we = 1; h_addr = 5'd2; h_wdata = 32'h2222_2222;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL lock_rdcap: got %b expected 00", {h_gnt, d_gnt}); end
    tick();
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, d_rvalid, d_rdata} !== {3'b011, 32'hA500_0007}) begin n_fail++; $display("FAIL lock_rdout: got %b %h expected 011 a5000007", {h_gnt, d_gnt, d_rvalid}, d_rdata); end
    tick(); d_req = 0;
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_hold: got %b expected 0", h_gnt); end
    tick(); d_lock = 0;
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_drop_cycle: got %b expected 0", h_gnt); end
    tick();
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_release: got %b expected 1", h_gnt); end
    tick(); h_req = 0;
  endtask

  task automatic test_read_then_dpu();
    h_req = 1; h_we = 0; h_addr = 5'd5;
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL rtd_hgnt: got %b expected 1", h_gnt); end
    tick();
    h_req = 0; d_req = 1; d_we = 0; d_addr = 5'd9;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, h_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rtd_rdcap: got %b expected 000", {h_gnt, d_gnt, h_rvalid}); end
    tick();
    @(negedge clk);
    n_checks++; if ({d_gnt, h_rvalid, h_rdata} !== {2'b11, 32'hA500_0005}) begin n_fail++; $display("FAIL rtd_rdout: got %b %h expected 11 a5000005", {d_gnt, h_rvalid}, h_rdata); end
    tick(); d_req = 0;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, d_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rtd_dcap: got %b expected 000", {h_gnt, d_gnt, d_rvalid}); end
    tick();
    @(negedge clk);
    n_checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h1000_0001}) begin n_fail++; $display("FAIL rtd_ddata: got %b %h expected 1 10000001", d_rvalid, d_rdata); end
    n_checks++; if ({h_rvalid, h_rdata} !== {1'b0, 32'hA500_0005}) begin n_fail++; $display("FAIL rtd_hkeep: got %b %h expected 0 a5000005", h_rvalid, h_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    h_req = 1; h_we = 0; h_addr = 5'd3;
    @(negedge clk);
    n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL mrst_gnt: got %b expected 1", h_gnt); end
    tick();
    h_req = 0; rst_n = 0;
    @(negedge clk);
    n_checks++; if ({h_gnt, d_gnt, h_rvalid, d_rvalid, sram_csb_n, sram_we_n} !== 6'b000011) begin n_fail++; $display("FAIL mrst_ctrl: got %b expected 000011", {h_gnt, d_gnt, h_rvalid, d_rvalid, sram_csb_n, sram_we_n}); end
    n_checks++; if ({h_rdata, d_rdata, sram_addr, sram_din} !== '0) begin n_fail++; $display("FAIL mrst_data: got %h %h %h %h expected all 0", h_rdata, d_rdata, sram_addr, sram_din); end
    tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (h_rvalid !== 1'b0) begin n_fail++; $display("FAIL mrst_no_rvalid%0d: got %b expected 0", i, h_rvalid); end
      tick();
    end
    h_req = 1; h_we = 1; h_addr = 5'd4; h_wdata = 32'h4444_0004;
    @(negedge clk);
    n_checks++; if ({h_gnt, sram_csb_n} !== 2'b10) begin n_fail++; $display("FAIL mrst_regrant: got %b expected 10", {h_gnt, sram_csb_n}); end
    tick(); h_req = 0;
  endtask

  task automatic test_random();
    rd_t               pend[$];
    logic [DW-1:0]     ref_mem [32];
    logic [DW-1:0]     exp_rdata [2];
    logic [AW+DW+1:0]  exp_bus;
    int                last, owner, win, exp_rv;
    bit                nogrant, ch, cd, wwe, wlock, h_granted, d_granted;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    apply_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    last = 1; owner = -1; nogrant = 0; h_granted = 0; d_granted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!h_req || h_granted) begin
        h_req = 1'($urandom_range(0, 1)); h_we = 1'($urandom_range(0, 1));
        h_addr = 5'($urandom_range(0, 31)); h_wdata = $urandom();
      end else if ($urandom_range(0, 15) == 0) h_req = 0;
      if (!d_req || d_granted) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 5'($urandom_range(0, 31)); d_wdata = $urandom();
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      h_lock = ($urandom_range(0, 2) == 0);
      d_lock = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_rv = -1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_rv = pend[0].port;
        exp_rdata[pend[0].port] = pend[0].data;
        void'(pend.pop_front());
      end
      ch = !nogrant && h_req && owner != 1;
      cd = !nogrant && d_req && owner != 0;
      win = -1;
      if (ch && cd) win = 1 - last;
      else if (ch)  win = 0;
      else if (cd)  win = 1;
      wwe = (win == 1) ? d_we : h_we;
      wlock = (win == 1) ? d_lock : h_lock;
      waddr = (win == 1) ? d_addr : h_addr;
      wdata = (win == 1) ? d_wdata : h_wdata;
      exp_bus = (win < 0) ? {2'b11, {AW{1'b0}}, {DW{1'b0}}} : {1'b0, !wwe, waddr, wdata};
      n_checks++; if ({h_gnt, d_gnt} !== {win == 0, win == 1}) begin n_fail++; $display("FAIL rnd_gnt cyc%0d: got h/d %b expected %b", cyc, {h_gnt, d_gnt}, {win == 0, win == 1}); end
      n_checks++; if ({sram_csb_n, sram_we_n, sram_addr, sram_din} !== exp_bus) begin n_fail++; $display("FAIL rnd_bus cyc%0d: got %h expected %h", cyc, {sram_csb_n, sram_we_n, sram_addr, sram_din}, exp_bus); end
      n_checks++; if ({h_rvalid, d_rvalid} !== {exp_rv == 0, exp_rv == 1}) begin n_fail++; $display("FAIL rnd_rvalid cyc%0d: got %b expected %b", cyc, {h_rvalid, d_rvalid}, {exp_rv == 0, exp_rv == 1}); end
      n_checks++; if ({h_rdata, d_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin n_fail++; $display("FAIL rnd_rdata cyc%0d: got %h/%h expected %h/%h", cyc, h_rdata, d_rdata, exp_rdata[0], exp_rdata[1]); end
      nogrant = (win >= 0) && !wwe;
      if ((owner == 0 && !h_lock) || (owner == 1 && !d_lock)) owner = -1;
      if (win >= 0) begin
        last = win;
        if (wlock) owner = win;
        if (wwe) ref_mem[waddr] = wdata;
        else     pend.push_back('{win, ref_mem[waddr], cyc + 2});
      end
      h_granted = (win == 0);
      d_granted = (win == 1);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

`ifdef SRAM_ARB_STATS_EN
  task automatic test_stats();
    int exp_cnt;
    apply_reset();
    h_we = 1;
    for (int i = 0; i < 5; i++) begin
      h_req = 1; h_addr = 5'(20 + i); h_wdata = 32'(i);
      @(negedge clk);
      n_checks++; if (h_gnt !== 1'b1) begin n_fail++; $display("FAIL stats_gnt%0d: got %b expected 1", i, h_gnt); end
      tick(); h_req = 0;
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      @(negedge clk);
      n_checks++; if (h_gnt_cnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL stats_hcnt%0d: got %0d expected %0d", i, h_gnt_cnt, exp_cnt); end
      n_checks++; if (d_gnt_cnt !== 2'd0) begin n_fail++; $display("FAIL stats_dcnt%0d: got %0d expected 0", i, d_gnt_cnt); end
      tick();
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_read_then_dpu();
    test_reset_mid_read();
    test_random();
`ifdef SRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
